i2c_poll_scheduler: RTL
=======================

// Module: i2c_poll_scheduler
// PURPOSE
//  Sequences the single-register I2C reader (start/ready/done/16-bit result) for the angle sensor.
//  Issues periodic polls plus on-demand requests, and merges coincident triggers into one transaction.
//  Enforces a per-transaction timeout and recovers a hung reader by pulsing its reset.
//  Publishes the latest 12-bit angle with a valid strobe and a stale/fault status for the FOC loop.
// PARAMETERS
//  PERIOD      24'd50000  clk cycles between periodic poll ticks (>=2)
//  TIMEOUT     20'd200000 clk cycles allowed from rd_start to rd_done (>=2)
//  MAX_RETRY   4'd3       consecutive timeouts before entering FAULT (>=1)
//  RST_CYCLES  4'd4       width of recovery reset pulse on rd_rstn (>=1)
// PORTS
//  clk          in   1   clock
//  rstn         in   1   synchronous active-low reset
//  en           in   1   enable periodic polling
//  req          in   1   on-demand read request, level; hold until req_ack
//  req_ack      out  1   1-cycle pulse: sample for the pending request delivered
//  rd_start     out  1   1-cycle start pulse to reader
//  rd_ready     in   1   reader idle
//  rd_done      in   1   reader 1-cycle completion pulse
//  rd_data      in   16  reader result; valid when rd_done=1
//  rd_rstn      out  1   active-low reset to reader
//  angle        out  12  latest good sample, rd_data[11:0]
//  angle_valid  out  1   1-cycle pulse on angle update
//  stale        out  1   angle not trustworthy (no sample yet, or FAULT)
//  fault        out  1   MAX_RETRY consecutive timeouts; sticky until fault_clr
//  fault_clr    in   1   clear FAULT, resume scheduling
//  err_cnt      out  8   total timeouts, saturating at 255
// BEHAVIOUR
//  Interface: one clock, clk; reset rstn is synchronous and active-low.
//  Reset values: rd_start=0, rd_rstn=0 (rises the cycle after rstn=1), req_ack=0, angle=0,
//   angle_valid=0, stale=1, fault=0, err_cnt=0, state=IDLE, all counters/pending flags=0.
//  Reset mid-transaction: everything above reapplies; the reader is held in reset via rd_rstn.
//  Tick counter: while en=1, counts 0..PERIOD-1 and wraps; at PERIOD-1 it sets tick_pend.
//   - A tick while tick_pend=1 is dropped.
//   - en=0 holds the counter at 0 and clears tick_pend; an in-flight transaction still completes.
//  req=1 with no transaction serving it sets req_pend.
//  All outputs are registered. States:
//  IDLE:
//   - if (tick_pend|req_pend) & rd_ready & ~fault -> START.
//  START:
//   - rd_start=1 for exactly 1 cycle; served_req<=req_pend; clear tick_pend and req_pend.
//   - timer<=0 -> WAIT. A tick and a req pending together produce one transaction.
//  WAIT: timer++ each cycle.
//   - On rd_done: angle<=rd_data[11:0]; next cycle angle_valid=1 and req_ack=served_req.
//     Also stale<=0, retry<=0 -> IDLE.
//   - On timer==TIMEOUT-1 without rd_done: err_cnt+=1 (saturating), retry+=1 -> RECOVER.
//   - rd_done in the same cycle as the timeout: rd_done wins, no error counted.
//  RECOVER:
//   - rd_rstn=0 for RST_CYCLES cycles, then 1.
//   - If retry==MAX_RETRY -> FAULT; else wait rd_ready -> START. served_req is kept for the retry.
//  FAULT:
//   - fault=1, stale=1; no rd_start issued; ticks are dropped; req_pend is retained with no ack.
//   - fault_clr=1 -> fault<=0, retry<=0 -> IDLE (stale stays 1 until the next good sample).
//  rd_done outside WAIT is ignored. rd_data[15:12] is discarded.
//  Latency: pending trigger to rd_start = 2 cycles when rd_ready=1.
// TESTING
//  PERIOD=100, en=1, reader model done 50 cycles after start, data 16'h0ABC -> one rd_start per 100
//   cycles; angle=12'hABC, angle_valid 1 pulse each; stale falls after first sample.
//  req and tick asserted in same cycle -> exactly one rd_start; req_ack and angle_valid pulse together.
//  Reader never returns done, TIMEOUT=300, MAX_RETRY=3 -> three rd_rstn low pulses of 4 cycles,
//   err_cnt=3, fault=1, stale=1, no further rd_start.
//  From FAULT, pulse fault_clr, reader healthy -> rd_start within 2 cycles of next tick; fault=0;
//   after done, stale=0.
//  rd_done coincident with timer==TIMEOUT-1 -> sample accepted, err_cnt unchanged;
//   rstn=0 mid-WAIT -> all outputs at reset values, rd_rstn=0.
//  en=0 mid-WAIT -> transaction completes with angle_valid; no new periodic rd_start while en=0.

Source files
------------

// File: rtl/i2c_poll_scheduler.sv
// i2c_poll_scheduler: schedules periodic and on-demand reads of the angle sensor through a single-register I2C reader,
// with per-transaction timeout, reader reset recovery and a sticky fault after repeated timeouts.
// Ports: clk/rstn (sync, active-low); en enables periodic ticks; req/req_ack on-demand handshake;
// rd_start/rd_ready/rd_done/rd_data/rd_rstn talk to the reader; angle/angle_valid publish samples;
// stale/fault/fault_clr/err_cnt report health.
module i2c_poll_scheduler #(
    parameter logic [23:0] PERIOD     = 24'd50000,
    parameter logic [19:0] TIMEOUT    = 20'd200000,
    parameter logic [3:0]  MAX_RETRY  = 4'd3,
    parameter logic [3:0]  RST_CYCLES = 4'd4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        req,
    output logic        req_ack,
    output logic        rd_start,
    input  logic        rd_ready,
    input  logic        rd_done,
    input  logic [15:0] rd_data,
    output logic        rd_rstn,
    output logic [11:0] angle,
    output logic        angle_valid,
    output logic        stale,
    output logic        fault,
    input  logic        fault_clr,
    output logic [7:0]  err_cnt
);
    typedef enum logic [2:0] {IDLE, START, WAIT, RECOVER, FAULT} state_t;
    state_t state, nxt;
    logic [23:0] tick_cnt;
    logic [19:0] timer;
    logic [3:0]  retry, rst_cnt;
    logic        tick_pend, req_pend, served_req;
    logic        tick_hit, timeout, to_hit, clr_hit;
    logic        rd_start_d, rd_rstn_d, angle_valid_d, req_ack_d, fault_d, stale_d;

    assign tick_hit = en && tick_cnt == PERIOD - 24'd1;
    assign timeout  = timer == TIMEOUT - 20'd1;
    assign to_hit   = state == WAIT && timeout && !rd_done;
    assign clr_hit  = state == FAULT && fault_clr;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if ((tick_pend || req_pend) && rd_ready && !fault) nxt = START;
            START:   nxt = WAIT;
            WAIT:    nxt = rd_done ? IDLE : timeout ? RECOVER : WAIT;
            // wait for the reset pulse to finish before deciding between retry and fault
            RECOVER: if (rd_rstn) nxt = retry == MAX_RETRY ? FAULT : rd_ready ? START : RECOVER;
            FAULT:   if (fault_clr) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_start_d    = nxt == START;
        angle_valid_d = state == WAIT && rd_done;
        req_ack_d     = angle_valid_d && served_req;
        fault_d       = nxt == FAULT;
        stale_d       = fault_d ? 1'b1 : angle_valid_d ? 1'b0 : stale;
        rd_rstn_d     = to_hit ? 1'b0 : (state == RECOVER && !rd_rstn) ? rst_cnt == RST_CYCLES - 4'd1 : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tick_cnt    <= '0;
            tick_pend   <= 1'b0;
            req_pend    <= 1'b0;
            served_req  <= 1'b0;
            timer       <= '0;
            retry       <= '0;
            rst_cnt     <= '0;
            err_cnt     <= '0;
            angle       <= '0;
            angle_valid <= 1'b0;
            req_ack     <= 1'b0;
            rd_start    <= 1'b0;
            rd_rstn     <= 1'b0;
            stale       <= 1'b1;
            fault       <= 1'b0;
        end else begin
            tick_cnt    <= !en ? 24'd0 : tick_hit ? 24'd0 : tick_cnt + 24'd1;
            tick_pend   <= !en ? 1'b0 : (tick_hit && state != FAULT) ? 1'b1 : state == START ? 1'b0 : tick_pend;
            // a request already being served (or just acked) must not re-arm itself
            req_pend    <= state == START ? 1'b0 : (clr_hit && served_req) ? 1'b1 :
                           (req && !served_req && !req_ack) ? 1'b1 : req_pend;
            served_req  <= state == START ? (served_req || req_pend) : (angle_valid_d || clr_hit) ? 1'b0 : served_req;
            timer       <= state == WAIT ? timer + 20'd1 : 20'd0;
            retry       <= (angle_valid_d || clr_hit) ? 4'd0 : to_hit ? retry + 4'd1 : retry;
            rst_cnt     <= (state == RECOVER && !rd_rstn) ? rst_cnt + 4'd1 : 4'd0;
            err_cnt     <= (to_hit && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
            angle       <= angle_valid_d ? rd_data[11:0] : angle;
            angle_valid <= angle_valid_d;
            req_ack     <= req_ack_d;
            rd_start    <= rd_start_d;
            rd_rstn     <= rd_rstn_d;
            stale       <= stale_d;
            fault       <= fault_d;
        end
    end
endmodule
